// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes,
// R-type funct codes and the ALU operation codes driven to the alu block.
`timescale 1ns/1ps
package mc_controller_pkg;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_R_EXEC    = 4'd6,
      ST_R_WB      = 4'd7,
      ST_BRANCH    = 4'd8,
      ST_JUMP      = 4'd9,
      ST_JAL       = 4'd10,
      ST_JR        = 4'd11,
      ST_I_EXEC    = 4'd12,
      ST_I_WB      = 4'd13,
      ST_ILLEGAL   = 4'd14
   } state_e;

   // ALU_OPERATION_DEFINES
   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_XOR  = 4'd2;
   localparam logic [3:0] ALU_NOR  = 4'd3;
   localparam logic [3:0] ALU_ADD  = 4'd4;
   localparam logic [3:0] ALU_ADDU = 4'd5;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_SUBU = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_SLL  = 4'd10;
   localparam logic [3:0] ALU_SRL  = 4'd11;
   localparam logic [3:0] ALU_SRA  = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/mc_controller_alu_op_decode.sv
// Combinational ALU operation select for the controller: R-type funct in R_EXEC,
// I-type opcode in I_EXEC, SUBU compare in BRANCH, ADDU everywhere else.
`timescale 1ns/1ps
module alu_op_decode
   import mc_controller_pkg::*;
(
   input  state_e     state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] alu_operation,
   output logic       illegal_funct
);

   logic [3:0] r_op;
   logic [3:0] i_op;

   always_comb begin
      r_op          = ALU_ADDU;
      illegal_funct = 1'b0;
      case (funct)
         FN_ADD:  r_op = ALU_ADD;
         FN_ADDU: r_op = ALU_ADDU;
         FN_SUB:  r_op = ALU_SUB;
         FN_SUBU: r_op = ALU_SUBU;
         FN_AND:  r_op = ALU_AND;
         FN_OR:   r_op = ALU_OR;
         FN_XOR:  r_op = ALU_XOR;
         FN_NOR:  r_op = ALU_NOR;
         FN_SLT:  r_op = ALU_SLT;
         FN_SLTU: r_op = ALU_SLTU;
         FN_SLL:  r_op = ALU_SLL;
         FN_SRL:  r_op = ALU_SRL;
         FN_SRA:  r_op = ALU_SRA;
         default: illegal_funct = 1'b1;
      endcase
   end

   always_comb begin
      i_op = ALU_ADDU;
      case (opcode)
         OP_ADDI:  i_op = ALU_ADD;
         OP_SLTI:  i_op = ALU_SLT;
         OP_SLTIU: i_op = ALU_SLTU;
         OP_ANDI:  i_op = ALU_AND;
         OP_ORI:   i_op = ALU_OR;
         OP_XORI:  i_op = ALU_XOR;
         default:  i_op = ALU_ADDU;
      endcase
   end

   always_comb begin
      alu_operation = ALU_ADDU;
      case (state)
         ST_R_EXEC: alu_operation = r_op;
         ST_I_EXEC: alu_operation = i_op;
         ST_BRANCH: alu_operation = ALU_SUBU;
         default:   alu_operation = ALU_ADDU;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit: Moore FSM driving datapath selects/enables and
// the ALU op; overflow on signed add/sub suppresses writeback and pulses ov_trap.
`timescale 1ns/1ps
module mc_controller
   import mc_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       overflow,
   output logic       pc_write,
   output logic       pc_write_cond_eq,
   output logic       pc_write_cond_ne,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic [1:0] alu_src_a,
   output logic [2:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [3:0] alu_operation,
   output logic       ov_trap,
   output logic       illegal,
   output logic [3:0] state
);

   state_e     state_q;
   state_e     state_d;
   logic       ov_pending;
   logic [3:0] exec_op;
   logic       illegal_funct;
   logic       unused_zero;

   // zero only qualifies the datapath's conditional PC write
   assign unused_zero = zero;

   alu_op_decode u_alu_op_decode (
      .state         (state_q),
      .opcode        (opcode),
      .funct         (funct),
      .alu_operation (exec_op),
      .illegal_funct (illegal_funct)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FETCH;
         ov_pending <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == ST_FETCH)
            ov_pending <= 1'b0;
         else if ((state_q == ST_R_EXEC || state_q == ST_I_EXEC) && overflow &&
                  (exec_op == ALU_ADD || exec_op == ALU_SUB))
            ov_pending <= 1'b1;
      end
   end

   always_comb begin
      state_d = ST_FETCH;
      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
               OP_RTYPE:       state_d = (funct == FN_JR) ? ST_JR : ST_R_EXEC;
               OP_BEQ, OP_BNE: state_d = ST_BRANCH;
               OP_J:           state_d = ST_JUMP;
               OP_JAL:         state_d = ST_JAL;
               OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
               OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                               state_d = ST_I_EXEC;
               default:        state_d = ST_ILLEGAL;
            endcase
         end
         ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
         ST_MEM_READ: state_d = ST_MEM_WB;
         ST_R_EXEC:   state_d = illegal_funct ? ST_ILLEGAL : ST_R_WB;
         ST_I_EXEC:   state_d = ST_I_WB;
         default:     state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      pc_write         = 1'b0;
      pc_write_cond_eq = 1'b0;
      pc_write_cond_ne = 1'b0;
      iord             = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      ir_write         = 1'b0;
      reg_write        = 1'b0;
      reg_dst          = 2'd0;
      mem_to_reg       = 2'd0;
      alu_src_a        = 2'd0;
      alu_src_b        = 3'd0;
      pc_source        = 2'd0;
      alu_operation    = exec_op;
      ov_trap          = 1'b0;
      illegal          = 1'b0;
      case (state_q)
         ST_FETCH: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 3'd1;
         end
         ST_DECODE: alu_src_b = 3'd3;
         ST_MEM_ADDR: begin
            alu_src_a = 2'd1;
            alu_src_b = 3'd2;
         end
         ST_MEM_READ: begin
            iord     = 1'b1;
            mem_read = 1'b1;
         end
         ST_MEM_WB: begin
            mem_to_reg = 2'd1;
            reg_write  = 1'b1;
         end
         ST_MEM_WRITE: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         ST_R_EXEC: alu_src_a = 2'd1;
         ST_R_WB: begin
            reg_dst   = 2'd1;
            reg_write = ~ov_pending;
            ov_trap   = ov_pending;
         end
         ST_BRANCH: begin
            alu_src_a        = 2'd1;
            pc_source        = 2'd1;
            pc_write_cond_eq = (opcode == OP_BEQ);
            pc_write_cond_ne = (opcode == OP_BNE);
         end
         ST_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
         end
         ST_JAL: begin
            pc_write   = 1'b1;
            pc_source  = 2'd2;
            reg_write  = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
         end
         ST_JR: begin
            pc_write  = 1'b1;
            pc_source = 2'd3;
         end
         ST_I_EXEC: begin
            alu_src_a = 2'd1;
            case (opcode)
               OP_ANDI, OP_ORI, OP_XORI: alu_src_b = 3'd4;
               OP_LUI: begin
                  alu_src_a = 2'd2;
                  alu_src_b = 3'd5;
               end
               default: alu_src_b = 3'd2;
            endcase
         end
         ST_I_WB: begin
            reg_write = ~ov_pending;
            ov_trap   = ov_pending;
         end
         ST_ILLEGAL: illegal = 1'b1;
         default: ;
      endcase
      // Reset wins over everything so no enable leaks during an aborted instruction
      if (rst) begin
         pc_write         = 1'b0;
         pc_write_cond_eq = 1'b0;
         pc_write_cond_ne = 1'b0;
         iord             = 1'b0;
         mem_read         = 1'b0;
         mem_write        = 1'b0;
         ir_write         = 1'b0;
         reg_write        = 1'b0;
         reg_dst          = 2'd0;
         mem_to_reg       = 2'd0;
         alu_src_a        = 2'd0;
         alu_src_b        = 3'd0;
         pc_source        = 2'd0;
         alu_operation    = ALU_ADDU;
         ov_trap          = 1'b0;
         illegal          = 1'b0;
      end
   end

   assign state = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: instruction-level model predicts the state
// walk and every control output per cycle; a few literal checks pin the model.
`timescale 1ns/1ps
module tb_mc_controller;
   import mc_controller_pkg::*;

   typedef struct packed {
      logic       pc_write, cond_eq, cond_ne, iord, mem_read, mem_write, ir_write, reg_write;
      logic [1:0] reg_dst, mem_to_reg, alu_src_a;
      logic [2:0] alu_src_b;
      logic [1:0] pc_source;
      logic [3:0] alu_operation;
      logic       ov_trap, illegal;
      logic [3:0] state;
   } outs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [5:0] opcode = 6'h23, funct = 6'h00;
   logic zero = 1'b0, overflow = 1'b0;
   logic pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write, ir_write, reg_write;
   logic [1:0] reg_dst, mem_to_reg, alu_src_a, pc_source;
   logic [2:0] alu_src_b;
   logic [3:0] alu_operation, state;
   logic ov_trap, illegal;

   mc_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
      .pc_write(pc_write), .pc_write_cond_eq(pc_write_cond_eq), .pc_write_cond_ne(pc_write_cond_ne),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_operation(alu_operation),
      .ov_trap(ov_trap), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   outs_t act;
   assign act = {pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write,
                 ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source,
                 alu_operation, ov_trap, illegal, state};

   int    n_vec = 0;
   int    n_err = 0;
   outs_t exp_q[$];
   outs_t e_cur;
   outs_t obs[8];
   int    path_q[$];

   // ALU operation an instruction needs in its execute step (ADDU if none)
   function automatic logic [3:0] exec_op(logic [5:0] op, logic [5:0] fn);
      if (op == 6'h00) begin
         case (fn)
            6'h20: return ALU_ADD;   6'h21: return ALU_ADDU;
            6'h22: return ALU_SUB;   6'h23: return ALU_SUBU;
            6'h24: return ALU_AND;   6'h25: return ALU_OR;
            6'h26: return ALU_XOR;   6'h27: return ALU_NOR;
            6'h2A: return ALU_SLT;   6'h2B: return ALU_SLTU;
            6'h00: return ALU_SLL;   6'h02: return ALU_SRL;
            6'h03: return ALU_SRA;   default: return ALU_ADDU;
         endcase
      end
      case (op)
         6'h08: return ALU_ADD;  6'h0A: return ALU_SLT;  6'h0B: return ALU_SLTU;
         6'h0C: return ALU_AND;  6'h0D: return ALU_OR;   6'h0E: return ALU_XOR;
         default: return ALU_ADDU;
      endcase
   endfunction

   function automatic bit legal_r(logic [5:0] fn);
      return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                        6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
   endfunction

   // Sequence of states an instruction visits, FETCH first
   function automatic void build_path(logic [5:0] op, logic [5:0] fn);
      path_q.delete();
      path_q.push_back(0);
      path_q.push_back(1);
      if (op == 6'h23) begin
         path_q.push_back(2); path_q.push_back(3); path_q.push_back(4);
      end else if (op == 6'h2B) begin
         path_q.push_back(2); path_q.push_back(5);
      end else if (op == 6'h00 && fn == 6'h08) path_q.push_back(11);
      else if (op == 6'h00) begin
         path_q.push_back(6); path_q.push_back(legal_r(fn) ? 7 : 14);
      end else if (op == 6'h04 || op == 6'h05) path_q.push_back(8);
      else if (op == 6'h02) path_q.push_back(9);
      else if (op == 6'h03) path_q.push_back(10);
      else if (op >= 6'h08 && op <= 6'h0F) begin
         path_q.push_back(12); path_q.push_back(13);
      end else path_q.push_back(14);
   endfunction

   function automatic outs_t model(int st, logic [5:0] op, logic [5:0] fn, bit trap);
      outs_t o;
      o = '0;
      o.alu_operation = ALU_ADDU;
      o.state = 4'(st);
      case (st)
         0: begin o.mem_read = 1; o.ir_write = 1; o.pc_write = 1; o.alu_src_b = 3'd1; end
         1: o.alu_src_b = 3'd3;
         2: begin o.alu_src_a = 2'd1; o.alu_src_b = 3'd2; end
         3: begin o.iord = 1; o.mem_read = 1; end
         4: begin o.mem_to_reg = 2'd1; o.reg_write = 1; end
         5: begin o.iord = 1; o.mem_write = 1; end
         6: begin o.alu_src_a = 2'd1; o.alu_operation = exec_op(op, fn); end
         7: begin o.reg_dst = 2'd1; o.reg_write = !trap; o.ov_trap = trap; end
         8: begin
            o.alu_src_a = 2'd1; o.alu_operation = ALU_SUBU; o.pc_source = 2'd1;
            o.cond_eq = (op == 6'h04); o.cond_ne = (op == 6'h05);
         end
         9:  begin o.pc_write = 1; o.pc_source = 2'd2; end
         10: begin
            o.pc_write = 1; o.pc_source = 2'd2; o.reg_write = 1;
            o.reg_dst = 2'd2; o.mem_to_reg = 2'd2;
         end
         11: begin o.pc_write = 1; o.pc_source = 2'd3; end
         12: begin
            o.alu_src_a = 2'd1;
            o.alu_operation = exec_op(op, fn);
            if (op inside {6'h0C, 6'h0D, 6'h0E}) o.alu_src_b = 3'd4;
            else if (op == 6'h0F) begin o.alu_src_a = 2'd2; o.alu_src_b = 3'd5; end
            else o.alu_src_b = 3'd2;
         end
         13: begin o.reg_write = !trap; o.ov_trap = trap; end
         14: o.illegal = 1;
         default: ;
      endcase
      return o;
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e_cur = exp_q.pop_front();
         n_vec++;
         if (act !== e_cur) begin
            n_err++;
            $display("FAIL cycle_outputs t=%0t state=%0d act=%h required=%h", $time, e_cur.state, act, e_cur);
         end
      end
   end

   task automatic chk(input string nm, input int a, input int e);
      n_vec++;
      if (a != e) begin
         n_err++;
         $display("FAIL %s act=%0d required=%0d", nm, a, e);
      end
   endtask

   task automatic do_reset(input int n);
      outs_t z;
      z = '0;
      z.alu_operation = ALU_ADDU;
      rst = 1'b1;
      repeat (n) begin
         opcode = 6'h23;
         exp_q.push_back(z);
         @(negedge clk);
         @(posedge clk); #1;
      end
      rst = 1'b0;
   endtask

   // Runs up to max_cyc cycles of one instruction, recording DUT outputs in obs[]
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input logic ov, input int max_cyc);
      bit ovp;
      build_path(op, fn);
      ovp = ov && (exec_op(op, fn) == ALU_ADD || exec_op(op, fn) == ALU_SUB) &&
            !(op == 6'h00 && !legal_r(fn));
      for (int i = 0; i < path_q.size() && i < max_cyc; i++) begin
         opcode = op; funct = fn; zero = z; overflow = ov;
         exp_q.push_back(model(path_q[i], op, fn, ovp && (path_q[i] == 7 || path_q[i] == 13)));
         @(negedge clk);
         obs[i] = act;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset(3);
      run_instr(6'h23, 6'h00, 1'b0, 1'b0, 99);     // lw
      chk("post_reset_state", obs[0].state, 0);
      chk("post_reset_fetch_en", {obs[0].mem_read, obs[0].ir_write, obs[0].pc_write}, 7);
      chk("post_reset_src_b", obs[0].alu_src_b, 1);
      chk("post_reset_aluop", obs[0].alu_operation, ALU_ADDU);
      chk("lw_wb_state", obs[4].state, 4);
      chk("lw_wb_rw_m2r_dst", {obs[4].reg_write, obs[4].mem_to_reg, obs[4].reg_dst}, 3'b101 << 2);
      run_instr(6'h00, 6'h20, 1'b0, 1'b1, 99);     // add with overflow
      chk("add_ov_reg_write", obs[3].reg_write, 0);
      chk("add_ov_trap", obs[3].ov_trap, 1);
      run_instr(6'h00, 6'h21, 1'b0, 1'b1, 99);     // addu with overflow
      chk("addu_ov_reg_write", obs[3].reg_write, 1);
      chk("addu_ov_trap", obs[3].ov_trap, 0);
      run_instr(6'h04, 6'h00, 1'b1, 1'b0, 99);     // beq
      chk("beq_cond_eq", obs[2].cond_eq, 1);
      chk("beq_pc_source", obs[2].pc_source, 1);
      run_instr(6'h05, 6'h00, 1'b0, 1'b0, 99);     // bne
      chk("bne_cond_ne", obs[2].cond_ne, 1);
      chk("after_branch_fetch", state, 0);
      run_instr(6'h03, 6'h00, 1'b0, 1'b0, 99);     // jal
      chk("jal_ctl", {obs[2].pc_write, obs[2].reg_write, obs[2].reg_dst, obs[2].mem_to_reg}, 6'b111010);
      run_instr(6'h00, 6'h08, 1'b0, 1'b0, 99);     // jr
      chk("jr_pc_source", obs[2].pc_source, 3);
      run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 99);     // illegal opcode
      chk("illegal_pulse", {obs[2].state, obs[2].illegal}, 29);
      chk("illegal_then_fetch", state, 0);
      run_instr(6'h0F, 6'h00, 1'b0, 1'b0, 99);     // lui
      chk("lui_srcs", {obs[2].alu_src_a, obs[2].alu_src_b}, 5'b10101);
      chk("lui_aluop", obs[2].alu_operation, ALU_ADDU);
      run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 99);     // sw
      run_instr(6'h00, 6'h22, 1'b0, 1'b1, 99);     // sub overflow
      run_instr(6'h00, 6'h23, 1'b0, 1'b1, 99);     // subu overflow ignored
      run_instr(6'h08, 6'h00, 1'b0, 1'b1, 99);     // addi overflow
      chk("addi_ov_trap", obs[3].ov_trap, 1);
      run_instr(6'h09, 6'h00, 1'b0, 1'b1, 99);     // addiu overflow ignored
      run_instr(6'h0A, 6'h00, 1'b0, 1'b1, 99);     // slti
      run_instr(6'h0C, 6'h00, 1'b0, 1'b0, 99);     // andi
      run_instr(6'h0E, 6'h00, 1'b0, 1'b0, 99);     // xori
      run_instr(6'h0B, 6'h00, 1'b0, 1'b0, 99);     // sltiu
      run_instr(6'h00, 6'h2A, 1'b0, 1'b0, 99);     // slt
      run_instr(6'h00, 6'h03, 1'b0, 1'b0, 99);     // sra
      run_instr(6'h00, 6'h27, 1'b0, 1'b0, 99);     // nor
      run_instr(6'h00, 6'h01, 1'b0, 1'b1, 99);     // illegal funct
      chk("bad_funct_illegal", obs[3].illegal, 1);
      run_instr(6'h02, 6'h00, 1'b0, 1'b0, 99);     // j
      run_instr(6'h23, 6'h00, 1'b0, 1'b0, 3);      // lw aborted by reset
      do_reset(1);
      run_instr(6'h00, 6'h20, 1'b0, 1'b1, 3);      // add aborted before writeback
      do_reset(1);
      run_instr(6'h00, 6'h20, 1'b0, 1'b0, 99);     // add, no overflow
      chk("add_clean_reg_write", obs[3].reg_write, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle MIPS control unit; sits directly upstream of `alu` and the datapath registers (PC, IR, A/B, ALUOut, MDR). A 4-bit Moore FSM walks each instruction through fetch/decode/execute/memory/writeback. It drives every datapath select and write enable, and the `ALU_operation` code. It consumes the ALU `zero` and `overflow` flags for branches and signed-overflow write suppression.

## Interface
- No parameters; state, opcode, funct and ALU codes come from shared defines.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26]. `funct` in 6: IR[5:0]; both stable from DECODE onward.
- `zero`, `overflow` in 1 each: from `alu`, same cycle.
- `pc_write`, `pc_write_cond_eq`, `pc_write_cond_ne`, `iord`, `mem_read`, `mem_write`, `ir_write`, `reg_write` out 1 each.
- `reg_dst` out 2: 0 rt, 1 rd, 2 r31.
- `mem_to_reg` out 2: 0 ALUOut, 1 MDR, 2 PC.
- `alu_src_a` out 2: 0 PC, 1 A, 2 zero.
- `alu_src_b` out 3: 0 B, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2, 4 zero-ext imm, 5 imm<<16.
- `pc_source` out 2: 0 ALU result, 1 ALUOut, 2 jump target, 3 A.
- `alu_operation` out 4: `ALU_OPERATION_DEFINES` code.
- `ov_trap`, `illegal` out 1 each: one-cycle pulses. `state` out 4: debug.

## Operation
- Outputs not listed for a state are 0, except `alu_operation`, which is ADDU.
- State encodings and per-state outputs:
  - FETCH=0: mem_read, ir_write, pc_write; src_a 0, src_b 1, ADDU, pc_source 0.
  - DECODE=1: src_a 0, src_b 3, ADDU (branch target into ALUOut).
  - MEM_ADDR=2: src_a 1, src_b 2, ADDU.
  - MEM_READ=3: iord, mem_read.
  - MEM_WB=4: reg_dst 0, mem_to_reg 1, reg_write.
  - MEM_WRITE=5: iord, mem_write.
  - R_EXEC=6: src_a 1, src_b 0, op from funct.
  - R_WB=7: reg_dst 1, mem_to_reg 0, reg_write unless ov_pending.
  - BRANCH=8: src_a 1, src_b 0, SUBU, pc_source 1; beq drives cond_eq, bne drives cond_ne.
  - JUMP=9: pc_write, pc_source 2.
  - JAL=10: pc_write, pc_source 2, reg_write, reg_dst 2, mem_to_reg 2.
  - JR=11: pc_write, pc_source 3.
  - I_EXEC=12: src_a 1; src_b 4 for andi/ori/xori, src_b 5 with src_a 2 for lui, else src_b 2; op from opcode.
  - I_WB=13: reg_dst 0, mem_to_reg 0, reg_write unless ov_pending.
  - ILLEGAL=14: `illegal`=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE dispatch by opcode: lw(23h)/sw(2Bh)→MEM_ADDR; 00h→R_EXEC, except funct 08h→JR; beq(04h)/bne(05h)→BRANCH; j(02h)→JUMP; jal(03h)→JAL; 08h–0Fh→I_EXEC; anything else→ILLEGAL.
  - MEM_ADDR→MEM_READ (lw) or MEM_WRITE (sw); MEM_READ→MEM_WB.
  - R_EXEC→R_WB; I_EXEC→I_WB.
  - MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH, JUMP, JAL, JR, ILLEGAL→FETCH.
  - Unused encoding 15→FETCH.
- R funct→op: 20h ADD, 21h ADDU, 22h SUB, 23h SUBU, 24h AND, 25h OR, 26h XOR, 27h NOR, 2Ah SLT, 2Bh SLTU, 00h SLL, 02h SRL, 03h SRA.
- Other R funct: R_EXEC→ILLEGAL, with no writeback.
- I opcode→op: 08h ADD, 09h ADDU, 0Ah SLT, 0Bh SLTU, 0Ch AND, 0Dh OR, 0Eh XOR, 0Fh ADDU.
- ov_pending:
  - Set at the end of R_EXEC/I_EXEC when `overflow`=1 and op is ADD or SUB.
  - Cleared on every FETCH entry and on reset.
  - When set in a WB state: reg_write is suppressed and `ov_trap`=1 for that cycle.
  - No exception vector; execution continues at PC+4.

## Timing
- Latencies (cycles per instruction): lw 5; sw, R-type and I-type 4; branch, j, jal, jr 3; illegal 3.
- Outputs are Moore: combinational functions of state and the stable opcode/funct only. `zero` and `overflow` are sampled only by the datapath (cond writes) and the ov_pending flop.
- Reset:
  - While `rst`=1, all outputs are forced 0 and `alu_operation` is ADDU.
  - The first edge with `rst`=1 loads FETCH and clears ov_pending.
  - The first FETCH cycle is the cycle after `rst` falls.
  - Reset mid-instruction aborts it; no enable is asserted during the reset cycle.

## Structure
- Shared defines include: state encodings, opcode and funct constants. ALU codes are reused from `ALU_OPERATION_DEFINES`.
- One combinational sub-module, `alu_op_decode`: (state, opcode, funct) → alu_operation, plus an illegal-funct flag.
- The top holds the state register, next-state logic, ov_pending and the output decode.

## Test plan
- Reset held 3 cycles with opcode=23h → all enables 0; after release, state=0, then mem_read=ir_write=pc_write=1, src_b=1, ADDU.
- lw (23h) → states 0,1,2,3,4,0; MEM_WB has reg_write=1, mem_to_reg=1, reg_dst=0.
- add (00h/20h), overflow=1 in R_EXEC → R_WB reg_write=0, ov_trap=1. Repeat with addu (21h) → reg_write=1, ov_trap=0.
- beq with zero=1 and bne with zero=0 → BRANCH asserts cond_eq and cond_ne respectively, pc_source=1; next state FETCH at cycle 3.
- jal (03h) → JAL state: pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2. jr (00h/08h) → pc_source=3.
- opcode 3Fh → ILLEGAL with illegal=1 for one cycle, then FETCH. lui (0Fh) → src_a=2, src_b=5, ADDU.
